commit_align_checker: RTL and testbench

- Parametrised successor to the two-copy commit comparator.
- Accepts per-lane commit streams from two core copies. Buffers commits from whichever copy runs ahead in a DEPTH-entry FIFO. Pairs the buffer in order against commits from the trailing copy.
- Flags load-data mismatches (invalid program) and commit misalignment (deviation).
- Drives the clock-gating stalls for the two copies; the leading copy is stalled only when the buffer cannot absorb another full commit group.

---
 rtl/commit_align_checker.sv | 172 +++++++++++++++++
 tb/tb_commit_align_checker.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_align_checker.sv
// commit_align_checker: pairs in-order commits of two core copies through
// a DEPTH-entry alignment buffer, flags load-data and commit-count deviations.
// Ports: clk, rst (async, active-high);
//   c1_valid/c1_ismem/c1_data and c2_* : per-lane commit streams;
//   stall_1/stall_2 : clock-gate requests; commit_deviation, invalid_program,
//   deviation_found : sticky flags; occupancy, lead, dev_cycle : status.
// Optional ADDR_OBSV_EN: adds c1_addr/c2_addr inputs and addr_deviation output.
module commit_align_checker #(
  parameter int COMMIT_W = 2,
  parameter int DATA_LEN = 32,
  parameter int DEPTH    = 4,
  parameter int CNT_W    = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [COMMIT_W-1:0]          c1_valid,
  input  logic [COMMIT_W-1:0]          c1_ismem,
  input  logic [COMMIT_W*DATA_LEN-1:0] c1_data,
  input  logic [COMMIT_W-1:0]          c2_valid,
  input  logic [COMMIT_W-1:0]          c2_ismem,
  input  logic [COMMIT_W*DATA_LEN-1:0] c2_data,
`ifdef ADDR_OBSV_EN
  input  logic [31:0]                  c1_addr,
  input  logic [31:0]                  c2_addr,
  output logic                         addr_deviation,
`endif
  output logic                         stall_1,
  output logic                         stall_2,
  output logic                         commit_deviation,
  output logic                         invalid_program,
  output logic                         deviation_found,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic [1:0]                   lead,
  output logic [CNT_W-1:0]             dev_cycle
);

  localparam int OW = $clog2(DEPTH+1);
  localparam int SL = DEPTH + COMMIT_W;

  logic [DEPTH-1:0]               buf_m;
  logic [DEPTH-1:0][DATA_LEN-1:0] buf_d;
  logic [CNT_W-1:0]               cnt;

  int n1, n2, n_ld, n_tr, occ_i, len, nocc;
  logic                         lead2;
  logic [COMMIT_W-1:0]          ld_m, tr_m;
  logic [COMMIT_W*DATA_LEN-1:0] ld_d, tr_d;
  logic [SL-1:0]                s_m;
  logic [SL-1:0][DATA_LEN-1:0]  s_d;
  logic [DEPTH-1:0]             nb_m;
  logic [DEPTH-1:0][DATA_LEN-1:0] nb_d;
  logic [1:0]                   nlead;
  logic [OW-1:0]                occ_d;
  logic                         mism, st1_d, st2_d, dev_d, adev_set;

  // length of the contiguous valid prefix
  function automatic int pfx(input logic [COMMIT_W-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < COMMIT_W; i++)
      if (v[i] && n == i) n = i + 1;
    return n;
  endfunction

  always_comb begin
    n1    = stall_1 ? 0 : pfx(c1_valid);
    n2    = stall_2 ? 0 : pfx(c2_valid);
    lead2 = (lead == 2'b10);
    ld_m  = lead2 ? c2_ismem : c1_ismem;
    ld_d  = lead2 ? c2_data  : c1_data;
    tr_m  = lead2 ? c1_ismem : c2_ismem;
    tr_d  = lead2 ? c1_data  : c2_data;
    n_ld  = lead2 ? n2 : n1;
    n_tr  = lead2 ? n1 : n2;
    occ_i = int'(occupancy);
    len   = occ_i + n_ld;

    // lead stream: buffered entries, then the lead copy's lanes
    s_m = '0;
    s_d = '0;
    for (int k = 0; k < DEPTH; k++)
      if (k < occ_i) begin
        s_m[k] = buf_m[k];
        s_d[k] = buf_d[k];
      end
    for (int j = 0; j < COMMIT_W; j++)
      if (j < n_ld) begin
        s_m[occ_i+j] = ld_m[j];
        s_d[occ_i+j] = ld_d[j*DATA_LEN +: DATA_LEN];
      end

    mism = 1'b0;
    for (int j = 0; j < COMMIT_W; j++)
      if (j < n_tr && j < len && s_m[j] && tr_m[j] &&
          s_d[j] != tr_d[j*DATA_LEN +: DATA_LEN])
        mism = 1'b1;

    nb_m = '0;
    nb_d = '0;
    if (n_tr <= len) begin
      nocc = len - n_tr;
      for (int i = 0; i < DEPTH; i++) begin
        nb_m[i] = s_m[i+n_tr];
        nb_d[i] = s_d[i+n_tr];
      end
      nlead = (nocc == 0) ? 2'b00 : (lead2 ? 2'b10 : 2'b01);
    end else begin
      // trailing copy overtook the lead stream: its excess leads now
      nocc = n_tr - len;
      for (int j = 0; j < COMMIT_W; j++)
        if (j >= len) begin
          nb_m[j-len] = tr_m[j];
          nb_d[j-len] = tr_d[j*DATA_LEN +: DATA_LEN];
        end
      nlead = lead2 ? 2'b01 : 2'b10;
    end

    occ_d = OW'(nocc);
    st1_d = (nlead == 2'b01) && (nocc > DEPTH - COMMIT_W);
    st2_d = (nlead == 2'b10) && (nocc > DEPTH - COMMIT_W);

`ifdef ADDR_OBSV_EN
    adev_set = !stall_1 && !stall_2 && (c1_addr != c2_addr);
    dev_d = commit_deviation || (nocc != 0) || addr_deviation || adev_set;
`else
    adev_set = 1'b0;
    dev_d = commit_deviation || (nocc != 0);
`endif
  end

`ifdef ADDR_OBSV_EN
  assign deviation_found = commit_deviation | addr_deviation;
`else
  assign deviation_found = commit_deviation;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt              <= '0;
      buf_m            <= '0;
      buf_d            <= '0;
      occupancy        <= '0;
      lead             <= 2'b00;
      stall_1          <= 1'b0;
      stall_2          <= 1'b0;
      commit_deviation <= 1'b0;
      invalid_program  <= 1'b0;
      dev_cycle        <= '0;
`ifdef ADDR_OBSV_EN
      addr_deviation   <= 1'b0;
`endif
    end else begin
      cnt       <= (&cnt) ? cnt : cnt + 1'b1;
      buf_m     <= nb_m;
      buf_d     <= nb_d;
      occupancy <= occ_d;
      lead      <= nlead;
      stall_1   <= st1_d;
      stall_2   <= st2_d;
      if (mism) invalid_program <= 1'b1;
      if (occ_d != '0) commit_deviation <= 1'b1;
`ifdef ADDR_OBSV_EN
      if (adev_set) addr_deviation <= 1'b1;
`endif
      if (!deviation_found && dev_d) dev_cycle <= cnt;
    end
  end

  logic unused_adev;
  assign unused_adev = adev_set;

endmodule

// File: tb/tb_commit_align_checker.sv
// tb_commit_align_checker: vector table, hand sequences and randomized
// stimulus against a queue-based reference model.
module tb_commit_align_checker;
  localparam int CW    = 2;
  localparam int DL    = 32;
  localparam int DEPTH = 4;
  localparam int CNT_W = 16;
  localparam int OW    = $clog2(DEPTH+1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [CW-1:0] c1_valid, c1_ismem, c2_valid, c2_ismem;
  logic [CW*DL-1:0] c1_data, c2_data;
  logic stall_1, stall_2, commit_deviation, invalid_program;
  logic deviation_found;
  logic [OW-1:0] occupancy;
  logic [1:0] lead;
  logic [CNT_W-1:0] dev_cycle;
  logic [31:0] c1_addr = '0, c2_addr = '0;
`ifdef ADDR_OBSV_EN
  logic addr_deviation;
`endif

  always #5 clk = ~clk;

  commit_align_checker #(
    .COMMIT_W(CW), .DATA_LEN(DL), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .c1_valid(c1_valid), .c1_ismem(c1_ismem), .c1_data(c1_data),
    .c2_valid(c2_valid), .c2_ismem(c2_ismem), .c2_data(c2_data),
`ifdef ADDR_OBSV_EN
    .c1_addr(c1_addr), .c2_addr(c2_addr),
    .addr_deviation(addr_deviation),
`endif
    .stall_1(stall_1), .stall_2(stall_2),
    .commit_deviation(commit_deviation),
    .invalid_program(invalid_program),
    .deviation_found(deviation_found),
    .occupancy(occupancy), .lead(lead), .dev_cycle(dev_cycle)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [1:0] v1, m1, input logic [31:0] a0, a1,
                       input logic [1:0] v2, m2, input logic [31:0] b0, b1);
    c1_valid = v1; c1_ismem = m1; c1_data = {a1, a0};
    c2_valid = v2; c2_ismem = m2; c2_data = {b1, b0};
  endtask

  // called at a negedge; returns at the following negedge
  task automatic reset_dut();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    c1_addr = '0; c2_addr = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- reference model ----------------
  typedef struct { bit m; logic [31:0] d; } ent_t;
  ent_t mb[$];
  int ml, mcnt, mdev;
  bit ms1, ms2, mcd, mip, mad;

  function automatic void mreset();
    mb.delete();
    ml = 0; mcnt = 0; mdev = 0;
    ms1 = 0; ms2 = 0; mcd = 0; mip = 0; mad = 0;
  endfunction

  function automatic int pfx(input logic [1:0] v);
    int n;
    n = 0;
    while (n < CW && v[n]) n++;
    return n;
  endfunction

  function automatic void mstep(
    input logic [1:0] v1, m1, input logic [63:0] d1,
    input logic [1:0] v2, m2, input logic [63:0] d2,
    input logic [31:0] aa1, aa2);
    int n1, n2, lc;
    ent_t ls[$], tq[$];
    ent_t e, a, b;
    bit olddev, adset;
    n1 = ms1 ? 0 : pfx(v1);
    n2 = ms2 ? 0 : pfx(v2);
    lc = (ml == 2) ? 2 : 1;
    ls = mb;
    for (int i = 0; i < n1; i++) begin
      e.m = m1[i]; e.d = d1[i*32 +: 32];
      if (lc == 1) ls.push_back(e); else tq.push_back(e);
    end
    for (int i = 0; i < n2; i++) begin
      e.m = m2[i]; e.d = d2[i*32 +: 32];
      if (lc == 2) ls.push_back(e); else tq.push_back(e);
    end
    while (ls.size() > 0 && tq.size() > 0) begin
      a = ls.pop_front();
      b = tq.pop_front();
      if (a.m && b.m && a.d != b.d) mip = 1;
    end
`ifdef ADDR_OBSV_EN
    adset = !ms1 && !ms2 && (aa1 != aa2);
`else
    adset = 0;
    if (aa1 != aa2) adset = 0;
`endif
    olddev = mcd | mad;
    if (tq.size() > 0) begin mb = tq; ml = 3 - lc; end
    else begin mb = ls; ml = lc; end
    if (mb.size() == 0) ml = 0;
    ms1 = (ml == 1) && (mb.size() > DEPTH - CW);
    ms2 = (ml == 2) && (mb.size() > DEPTH - CW);
    if (mb.size() > 0) mcd = 1;
    if (adset) mad = 1;
    if (!olddev && (mcd | mad)) mdev = mcnt;
    if (mcnt < (1 << CNT_W) - 1) mcnt++;
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0] v1, m1; logic [31:0] a0, a1;
    logic [1:0] v2, m2; logic [31:0] b0, b1;
    int occ; int ld; bit s1, s2, cd, ip;
  } vec_t;
  vec_t tv[$];

  function automatic void add(
    input logic [1:0] v1, m1, input logic [31:0] a0, a1,
    input logic [1:0] v2, m2, input logic [31:0] b0, b1,
    input int occ, ld, input bit s1, s2, cd, ip);
    vec_t t;
    t.v1 = v1; t.m1 = m1; t.a0 = a0; t.a1 = a1;
    t.v2 = v2; t.m2 = m2; t.b0 = b0; t.b1 = b1;
    t.occ = occ; t.ld = ld; t.s1 = s1; t.s2 = s2; t.cd = cd; t.ip = ip;
    tv.push_back(t);
  endfunction

  initial begin
    logic [1:0] rv1, rm1, rv2, rm2;
    logic [63:0] rd1, rd2;
    logic [31:0] ra1, ra2;

    for (int i = 0; i < 5; i++)
      add(3, 3, 'h10, 'h20, 3, 3, 'h10, 'h20, 0, 0, 0, 0, 0, 0);
    add(3, 3, 1, 2,         3, 0, 3, 4,         0, 0, 0, 0, 0, 0);
    add(3, 3, 7, 8,         1, 1, 7, 'hBAD,     1, 1, 0, 0, 1, 0);
    add(0, 0, 0, 0,         1, 1, 8, 0,         0, 0, 0, 0, 1, 0);
    add(3, 3, 'hA, 'hB,     0, 0, 0, 0,         2, 1, 0, 0, 1, 0);
    add(3, 3, 'hC, 'hD,     0, 0, 0, 0,         4, 1, 1, 0, 1, 0);
    add(3, 3, 'hEE, 'hEE,   3, 3, 'hA, 'hB,     2, 1, 0, 0, 1, 0);
    add(0, 0, 0, 0,         1, 1, 'h99, 0,      1, 1, 0, 0, 1, 1);
    add(0, 0, 0, 0,         1, 1, 'hD, 0,       0, 0, 0, 0, 1, 1);
    add(1, 0, 5, 0,         0, 0, 0, 0,         1, 1, 0, 0, 1, 1);
    add(0, 0, 0, 0,         3, 0, 5, 6,         1, 2, 0, 0, 1, 1);
    add(1, 0, 9, 0,         0, 0, 0, 0,         0, 0, 0, 0, 1, 1);
    add(0, 0, 0, 0,         3, 3, 1, 2,         2, 2, 0, 0, 1, 1);
    add(0, 0, 0, 0,         3, 3, 3, 4,         4, 2, 0, 1, 1, 1);
    add(3, 3, 1, 2,         2, 3, 9, 9,         2, 2, 0, 0, 1, 1);
    add(2, 3, 7, 7,         0, 0, 0, 0,         2, 2, 0, 0, 1, 1);
    add(3, 3, 3, 4,         0, 0, 0, 0,         0, 0, 0, 0, 1, 1);

    // reset state
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #3;
    chk("rst_occ", occupancy, 0);
    chk("rst_lead", lead, 0);
    chk("rst_stalls", {stall_1, stall_2}, 0);
    chk("rst_flags", {commit_deviation, invalid_program, deviation_found}, 0);
    chk("rst_devcyc", dev_cycle, 0);
    reset_dut();

    foreach (tv[i]) begin
      drive(tv[i].v1, tv[i].m1, tv[i].a0, tv[i].a1,
            tv[i].v2, tv[i].m2, tv[i].b0, tv[i].b1);
      @(posedge clk); #1;
      chk($sformatf("tv%0d_occ", i), occupancy, tv[i].occ);
      chk($sformatf("tv%0d_lead", i), lead, tv[i].ld);
      chk($sformatf("tv%0d_stall1", i), stall_1, tv[i].s1);
      chk($sformatf("tv%0d_stall2", i), stall_2, tv[i].s2);
      chk($sformatf("tv%0d_cdev", i), commit_deviation, tv[i].cd);
      chk($sformatf("tv%0d_inv", i), invalid_program, tv[i].ip);
      @(negedge clk);
    end
    chk("tv_dev_cycle", dev_cycle, 6);

    // deviation in cycle 7, then asynchronous reset while stalled
    reset_dut();
    for (int i = 0; i < 7; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk); #1; @(negedge clk);
    end
    drive(3, 3, 'hA, 'hB, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk("c7_cdev", commit_deviation, 1);
    @(negedge clk);
    drive(3, 3, 'hC, 'hD, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk("c7_dev_cycle", dev_cycle, 7);
    chk("c7_stall1", stall_1, 1);
    chk("c7_occ", occupancy, 4);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_stall1", stall_1, 0);
    chk("arst_occ", occupancy, 0);
    chk("arst_lead", lead, 0);
    chk("arst_flags", {commit_deviation, deviation_found}, 0);
    chk("arst_devcyc", dev_cycle, 0);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 0, 3, 3, 'hA, 'hB);
    @(posedge clk); #1;
    chk("post_rst_occ", occupancy, 2);
    chk("post_rst_lead", lead, 2);
    chk("post_rst_inv", invalid_program, 0);
    @(negedge clk);

`ifdef ADDR_OBSV_EN
    reset_dut();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    c1_addr = 'h100; c2_addr = 'h104;
    @(posedge clk); #1;
    chk("addr_dev", addr_deviation, 1);
    chk("addr_devfound", deviation_found, 1);
    chk("addr_devcyc", dev_cycle, 0);
    chk("addr_cdev", commit_deviation, 0);
    @(negedge clk);
`endif

    // randomized run against the reference model
    for (int seg = 0; seg < 5; seg++) begin
      reset_dut();
      mreset();
      for (int cyc = 0; cyc < 400; cyc++) begin
        rv1 = 2'($urandom_range(0, 3));
        rv2 = 2'($urandom_range(0, 3));
        rm1 = 2'($urandom_range(0, 3));
        rm2 = 2'($urandom_range(0, 3));
        if (seg % 2 == 0) begin
          rd1 = {32'h55, 32'h55};
          rd2 = rd1;
        end else begin
          rd1 = {32'($urandom_range(0, 3)), 32'($urandom_range(0, 3))};
          rd2 = {32'($urandom_range(0, 3)), 32'($urandom_range(0, 3))};
        end
        ra1 = 32'h0;
        ra2 = 32'h0;
`ifdef ADDR_OBSV_EN
        ra1 = $urandom;
        ra2 = ($urandom_range(0, 99) == 0) ? (ra1 ^ 32'h4) : ra1;
`endif
        c1_addr = ra1; c2_addr = ra2;
        drive(rv1, rm1, rd1[31:0], rd1[63:32], rv2, rm2, rd2[31:0], rd2[63:32]);
        mstep(rv1, rm1, rd1, rv2, rm2, rd2, ra1, ra2);
        @(posedge clk); #1;
        chk("rnd_occ", occupancy, mb.size());
        chk("rnd_lead", lead, ml);
        chk("rnd_stall1", stall_1, ms1);
        chk("rnd_stall2", stall_2, ms2);
        chk("rnd_cdev", commit_deviation, mcd);
        chk("rnd_inv", invalid_program, mip);
        chk("rnd_devfound", deviation_found, mcd | mad);
        chk("rnd_devcyc", dev_cycle, mdev);
        chk("rnd_dual_stall", stall_1 & stall_2, 0);
        @(negedge clk);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
